muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the MUL (ALUControlD=5'b00100) and DIV (5'b00011) ops

---
 rtl/muldiv_seq.sv | 147 ++++++++++++++
 tb/tb_muldiv_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/DIV sequencer beside the EX-stage ALU.
// One bit per cycle: shift-add multiply or restoring divide; stalls the pipe until HI/LO are valid.
module muldiv_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_MUL = 5'b00100,
    parameter logic [4:0] OP_DIV = 5'b00011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 dbz_r;

    logic                 can_accept_s;
    logic                 is_mul_s;
    logic                 is_div_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH+1:0]     trial_s;
    logic [2*WIDTH-1:0]   step_s;

    // Decode request and compute one multiply/divide iteration.
    // The shifted remainder is WIDTH+1 bits wide so no dividend bit is lost before the trial subtract.
    always_comb begin
        can_accept_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        is_mul_s     = start && (alu_ctrl == OP_MUL);
        is_div_s     = start && (alu_ctrl == OP_DIV);
        mul_sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        rem_sh_s     = acc_r[2*WIDTH-1:WIDTH-1];
        trial_s      = {1'b0, rem_sh_s} - {2'b00, opnd_r};
        step_s       = acc_r;
        case (state_r)
            ST_MUL: step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
            ST_DIV: begin
                if (!trial_s[WIDTH+1]) begin
                    step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
                end else begin
                    step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
                end
            end
            default: step_s = acc_r;
        endcase
    end

    assign stall       = busy_r | (can_accept_s & (is_mul_s | is_div_s));
    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

    // Sequencer FSM, datapath registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {(2*WIDTH){1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (is_mul_s) begin
                        state_r <= ST_MUL;
                        busy_r  <= 1'b1;
                        acc_r   <= {{WIDTH{1'b0}}, src_b};
                        opnd_r  <= src_a;
                        cnt_r   <= CNT_INIT;
                    end else if (is_div_s) begin
                        state_r <= ST_DIV;
                        busy_r  <= 1'b1;
                        acc_r   <= {{WIDTH{1'b0}}, src_a};
                        opnd_r  <= src_b;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        acc_r <= step_s;
                        cnt_r <= cnt_r - CNT_LAST;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            hi_r    <= step_s[2*WIDTH-1:WIDTH];
                            lo_r    <= step_s[WIDTH-1:0];
                            dbz_r   <= (state_r == ST_DIV) && (opnd_r == {WIDTH{1'b0}});
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32).
// Inputs change and outputs are checked just after each falling edge.
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_BAD = 5'b00010;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.WIDTH(32), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
        .stall(stall), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic s, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
        @(negedge clk);
        start = s; alu_ctrl = c; src_a = a; src_b = b; flush = f;
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 5'b00000, 32'h0, 32'h0, 1'b0);
    endtask

    // Busy cycles with idle inputs: busy and stall high, no done.
    task automatic busy_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            idle_cyc();
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
        end
    endtask

    task automatic chk_result(input string tag, input logic [31:0] ehi,
                              input logic [31:0] elo, input logic edbz);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy0"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_ctrl = 5'b00000;
        src_a = 32'h0; src_b = 32'h0; flush = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: MUL 7*6, stall in issue cycle, 32 busy cycles, done at cycle 33
        cyc(1'b1, OP_MUL, 32'd7, 32'd6, 1'b0);
        chk("m1_issue_stall", {31'b0, stall}, 32'd1);
        chk("m1_issue_busy", {31'b0, busy}, 32'd0);
        busy_cycles(32, "m1");
        idle_cyc();
        chk_result("m1", 32'h0, 32'd42, 1'b0);
        chk("m1_done_stall", {31'b0, stall}, 32'd0);

        // 2: MUL all-ones squared, done is a single pulse, result holds
        cyc(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        busy_cycles(32, "m2");
        idle_cyc();
        chk_result("m2", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        idle_cyc();
        chk("m2_pulse", {31'b0, done}, 32'd0);
        chk("m2_hold_hi", hi, 32'hFFFF_FFFE);
        chk("m2_hold_lo", lo, 32'h0000_0001);

        // 3: DIV 100/7, then DIV 5/0 issued in the DONE cycle
        cyc(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        busy_cycles(32, "d1");
        cyc(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
        chk_result("d1", 32'd2, 32'd14, 1'b0);
        chk("d1_chain_stall", {31'b0, stall}, 32'd1);
        busy_cycles(32, "d0");
        idle_cyc();
        chk_result("d0", 32'd5, 32'hFFFF_FFFF, 1'b1);

        // 4: MUL 3*3 flushed at cycle 10, no done, previous results kept
        cyc(1'b1, OP_MUL, 32'd3, 32'd3, 1'b0);
        busy_cycles(9, "f1");
        cyc(1'b0, 5'b00000, 32'h0, 32'h0, 1'b1);
        chk("f1_flushcyc_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 36; i++) begin
            idle_cyc();
            chk("f1_after_busy", {31'b0, busy}, 32'd0);
            chk("f1_after_done", {31'b0, done}, 32'd0);
        end
        chk("f1_hi", hi, 32'd5);
        chk("f1_lo", lo, 32'hFFFF_FFFF);
        chk("f1_dbz", {31'b0, div_by_zero}, 32'd1);

        // flush in IDLE cancels a same-cycle start
        cyc(1'b1, OP_MUL, 32'd3, 32'd3, 1'b1);
        idle_cyc();
        chk("fi_cancel_busy", {31'b0, busy}, 32'd0);

        // 6: invalid code ignored; start during busy ignored; MUL clears div_by_zero
        cyc(1'b1, OP_BAD, 32'd9, 32'd9, 1'b0);
        chk("bad_stall", {31'b0, stall}, 32'd0);
        idle_cyc();
        chk("bad_busy", {31'b0, busy}, 32'd0);
        cyc(1'b1, OP_MUL, 32'd9, 32'd9, 1'b0);
        busy_cycles(5, "i1");
        cyc(1'b1, OP_DIV, 32'd1, 32'd1, 1'b0);
        chk("i1_midstart_stall", {31'b0, stall}, 32'd1);
        chk("i1_midstart_busy", {31'b0, busy}, 32'd1);
        busy_cycles(26, "i1b");
        idle_cyc();
        chk_result("i1", 32'h0, 32'd81, 1'b0);
        idle_cyc();
        chk("i1_idle_busy", {31'b0, busy}, 32'd0);

        // 5: async reset at cycle 15 of a DIV, then MUL 2*2
        cyc(1'b1, OP_DIV, 32'd50, 32'd3, 1'b0);
        busy_cycles(14, "r1");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r1_busy", {31'b0, busy}, 32'd0);
        chk("r1_done", {31'b0, done}, 32'd0);
        chk("r1_hi", hi, 32'h0);
        chk("r1_lo", lo, 32'h0);
        chk("r1_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, OP_MUL, 32'd2, 32'd2, 1'b0);
        busy_cycles(32, "r2");
        idle_cyc();
        chk_result("r2", 32'h0, 32'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
